// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//
// Memory-side responder for the pipeline's load/store port. It accepts one
// request per handshake and latches it. After a fixed wait it performs the
// access on a word-organised RAM with byte-lane writes. The result is held
// until the initiator takes it. RV32I size and sign rules apply to loads and
// stores. Illegal requests return an error and leave the RAM untouched.
//
// Parameters:
//   ADDR_WIDTH   word-address bits, RAM depth = 2**ADDR_WIDTH words
//   WAIT_CYCLES  extra cycles between acceptance and the memory access
//
// Ports:
//   clk          clock, all state on the rising edge
//   rst          asynchronous, active-high reset
//   req_valid    initiator presents a request
//   req_ready    responder can accept a request (IDLE only)
//   req_we       1 = store, 0 = load
//   req_addr     byte address
//   req_size     RV32I funct3 (LB/SB, LH/SH, LW/SW, LBU, LHU)
//   req_wdata    store data, right-aligned
//   resp_valid   response available
//   resp_ready   initiator consumes the response
//   resp_rdata   extended load result; 0 for stores and errors
//   resp_err     request was illegal, no memory side effect
// ---------------------------------------------------------------------------
module dmem_responder #(
   parameter int ADDR_WIDTH  = 10,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [2:0]  req_size,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

   localparam logic [2:0] SZ_B  = 3'b000;
   localparam logic [2:0] SZ_H  = 3'b001;
   localparam logic [2:0] SZ_W  = 3'b010;
   localparam logic [2:0] SZ_BU = 3'b100;
   localparam logic [2:0] SZ_HU = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t state;
   state_t state_next;

   logic [CNT_W-1:0]      cnt;
   logic                  lat_we;
   logic [31:0]           lat_addr;
   logic [2:0]            lat_size;
   logic [31:0]           lat_wdata;

   logic                  accept;
   logic                  access;
   logic                  release_resp;

   logic [ADDR_WIDTH-1:0] word_idx;
   logic [1:0]            lane;
   logic                  req_err;
   logic [3:0]            byte_en;
   logic [31:0]           wdata_lanes;
   logic [31:0]           word_rd;
   logic [7:0]            sel_byte;
   logic [15:0]           sel_half;
   logic [31:0]           load_data;

   logic [31:0]           mem [DEPTH];

   // Handshake qualifiers. The access fires on the last WAIT cycle, when the
   // counter has run down to zero.
   assign req_ready    = (state == S_IDLE) && !rst;
   assign resp_valid   = (state == S_RESP);
   assign accept       = req_valid && req_ready;
   assign access       = (state == S_WAIT) && (cnt == '0);
   assign release_resp = (state == S_RESP) && resp_ready;

   assign word_idx = lat_addr[ADDR_WIDTH+1:2];
   assign lane     = lat_addr[1:0];

   // State register. Reset aborts any request in flight. A request that has
   // not reached the access edge never touches the RAM.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic for the single-outstanding request sequencer.
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: if (accept)       state_next = S_WAIT;
         S_WAIT: if (access)       state_next = S_RESP;
         S_RESP: if (release_resp) state_next = S_IDLE;
         default:                  state_next = S_IDLE;
      endcase
   end

   // Request latch and wait counter. The counter only counts down while it is
   // nonzero, so it never wraps.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt       <= '0;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_size  <= '0;
         lat_wdata <= '0;
      end else if (accept) begin
         cnt       <= CNT_W'(WAIT_CYCLES);
         lat_we    <= req_we;
         lat_addr  <= req_addr;
         lat_size  <= req_size;
         lat_wdata <= req_wdata;
      end else if ((state == S_WAIT) && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   // Legality checks on the latched request. The range check uses a shift,
   // so it stays well-formed for any ADDR_WIDTH.
   always_comb begin
      req_err = 1'b0;
      if ((lat_size == 3'b011) || (lat_size[2:1] == 2'b11)) begin
         req_err = 1'b1;
      end
      if (lat_we && ((lat_size == SZ_BU) || (lat_size == SZ_HU))) begin
         req_err = 1'b1;
      end
      if ((lat_size[1:0] == 2'b01) && lat_addr[0]) begin
         req_err = 1'b1;
      end
      if ((lat_size == SZ_W) && (lat_addr[1:0] != 2'b00)) begin
         req_err = 1'b1;
      end
      if ((lat_addr >> (ADDR_WIDTH + 2)) != 32'd0) begin
         req_err = 1'b1;
      end
   end

   // Store lane enables. The store data is replicated across the word, so each
   // enabled lane picks up the right byte without a shifter.
   always_comb begin
      byte_en     = 4'b0000;
      wdata_lanes = lat_wdata;
      case (lat_size)
         SZ_B: begin
            byte_en     = 4'b0001 << lane;
            wdata_lanes = {4{lat_wdata[7:0]}};
         end
         SZ_H: begin
            byte_en     = lane[1] ? 4'b1100 : 4'b0011;
            wdata_lanes = {2{lat_wdata[15:0]}};
         end
         SZ_W: begin
            byte_en     = 4'b1111;
            wdata_lanes = lat_wdata;
         end
         default: begin
            byte_en     = 4'b0000;
            wdata_lanes = lat_wdata;
         end
      endcase
   end

   // Load path. The byte or halfword is taken from the addressed lane
   // (little-endian). It is then sign- or zero-extended according to funct3.
   always_comb begin
      word_rd   = mem[word_idx];
      sel_byte  = 8'h00;
      sel_half  = lane[1] ? word_rd[31:16] : word_rd[15:0];
      load_data = 32'h0000_0000;
      case (lane)
         2'd0:    sel_byte = word_rd[7:0];
         2'd1:    sel_byte = word_rd[15:8];
         2'd2:    sel_byte = word_rd[23:16];
         default: sel_byte = word_rd[31:24];
      endcase
      case (lat_size)
         SZ_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
         SZ_BU:   load_data = {24'h000000, sel_byte};
         SZ_H:    load_data = {{16{sel_half[15]}}, sel_half};
         SZ_HU:   load_data = {16'h0000, sel_half};
         SZ_W:    load_data = word_rd;
         default: load_data = 32'h0000_0000;
      endcase
   end

   // Response registers. They load on the access edge and hold through RESP.
   // They clear on the response handshake, so the data bus idles at zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         resp_rdata <= 32'h0000_0000;
         resp_err   <= 1'b0;
      end else if (access) begin
         resp_err   <= req_err;
         resp_rdata <= (req_err || lat_we) ? 32'h0000_0000 : load_data;
      end else if (release_resp) begin
         resp_rdata <= 32'h0000_0000;
         resp_err   <= 1'b0;
      end
   end

   // RAM write port. It has no reset, so contents survive a reset. It commits
   // only on the access edge of a legal store.
   always_ff @(posedge clk) begin
      if (access && lat_we && !req_err) begin
         for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) begin
               mem[word_idx][8*i +: 8] <= wdata_lanes[8*i +: 8];
            end
         end
      end
   end

endmodule
